// File: rtl/amf_rc_int_fifo_level_mon.sv
// amf_rc_int_fifo_level_mon: per-channel FIFO occupancy counters with sticky
// overflow/underflow flags, hysteretic high-watermark status bits, a
// registered summary interrupt and a round-robin valid/ack interrupt-ID port.
module amf_rc_int_fifo_level_mon #(
    parameter int unsigned NumRcInt = 8,
    parameter int unsigned Depth    = 7,
    parameter int unsigned LvlW     = $clog2(Depth + 1)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NumRcInt-1:0]                               push_i,
    input  logic [NumRcInt-1:0]                               pop_i,
    input  logic [LvlW-1:0]                                   hi_wm_i,
    input  logic [LvlW-1:0]                                   lo_wm_i,
    input  logic [NumRcInt-1:0]                               int_mask_i,
    input  logic [NumRcInt-1:0]                               int_clr_i,
    input  logic [NumRcInt-1:0]                               err_clr_i,
    output logic [NumRcInt-1:0][LvlW-1:0]                     amf_rc_int_fifo_level,
    output logic [NumRcInt-1:0]                               int_status_o,
    output logic [NumRcInt-1:0]                               ovf_o,
    output logic [NumRcInt-1:0]                               udf_o,
    output logic                                              irq_o,
    output logic                                              irq_valid_o,
    output logic [((NumRcInt > 1) ? $clog2(NumRcInt) : 1)-1:0] irq_id_o,
    input  logic                                              irq_ack_i
);

    localparam int unsigned     IdW    = (NumRcInt > 1) ? $clog2(NumRcInt) : 1;
    localparam logic [LvlW-1:0] DepthL = LvlW'(Depth);

    typedef enum logic {HYST_LOW, HYST_HIGH} hyst_e;
    typedef enum logic {ID_IDLE, ID_VALID}   id_state_e;

    logic [NumRcInt-1:0][LvlW-1:0] lvl_q, lvl_d;
    logic [NumRcInt-1:0]           ovf_q, ovf_d;
    logic [NumRcInt-1:0]           udf_q, udf_d;
    logic [NumRcInt-1:0]           status_q, status_d;
    logic [NumRcInt-1:0]           rise_q, rise_d;
    hyst_e                         hyst_q [NumRcInt];
    hyst_e                         hyst_d [NumRcInt];
    logic                          irq_q, irq_d;
    id_state_e                     id_state_q, id_state_d;
    logic [IdW-1:0]                id_q, id_d;
    logic [IdW-1:0]                rr_q, rr_d;
    logic [NumRcInt-1:0]           pending;
    logic [NumRcInt-1:0]           ack_clr;
    logic                          sel_found;
    logic [IdW-1:0]                sel_id;

    // Occupancy counters; simultaneous push and pop cancel with no error flag.
    always_comb begin
        lvl_d = lvl_q;
        ovf_d = ovf_q & ~err_clr_i;
        udf_d = udf_q & ~err_clr_i;
        for (int unsigned i = 0; i < NumRcInt; i++) begin
            if (push_i[i] && !pop_i[i]) begin
                if (lvl_q[i] == DepthL) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    lvl_d[i] = lvl_q[i] + 1'b1;
                end
            end else if (pop_i[i] && !push_i[i]) begin
                if (lvl_q[i] == '0) begin
                    udf_d[i] = 1'b1;
                end else begin
                    lvl_d[i] = lvl_q[i] - 1'b1;
                end
            end
        end
    end

    // Watermark hysteresis on the registered level; rise_d pulses on LOW->HIGH only.
    always_comb begin
        rise_d = '0;
        for (int unsigned i = 0; i < NumRcInt; i++) begin
            hyst_d[i] = hyst_q[i];
            if (hi_wm_i == '0) begin
                hyst_d[i] = HYST_LOW;
            end else if ((hyst_q[i] == HYST_LOW) && (lvl_q[i] >= hi_wm_i)) begin
                hyst_d[i] = HYST_HIGH;
                rise_d[i] = 1'b1;
            end else if ((hyst_q[i] == HYST_HIGH) && (lvl_q[i] <= lo_wm_i)) begin
                hyst_d[i] = HYST_LOW;
            end
        end
    end

    // Sticky status with set priority over software clear and ack clear.
    always_comb begin
        ack_clr = '0;
        if ((id_state_q == ID_VALID) && irq_ack_i) begin
            ack_clr[id_q] = 1'b1;
        end
        pending  = status_q & ~int_mask_i;
        irq_d    = |pending;
        status_d = (status_q & ~int_clr_i & ~ack_clr) | rise_q;
    end

    // ID port: pick first pending channel at or after rr_q (wrapping), hold until ack.
    always_comb begin
        id_state_d = id_state_q;
        id_d       = id_q;
        rr_d       = rr_q;
        sel_found  = 1'b0;
        sel_id     = '0;
        // Two ascending scans: the first covers rr_q..top, the second wraps to 0.
        for (int unsigned i = 0; i < NumRcInt; i++) begin
            if (!sel_found && pending[i] && (i >= 32'(rr_q))) begin
                sel_found = 1'b1;
                sel_id    = IdW'(i);
            end
        end
        for (int unsigned i = 0; i < NumRcInt; i++) begin
            if (!sel_found && pending[i]) begin
                sel_found = 1'b1;
                sel_id    = IdW'(i);
            end
        end
        case (id_state_q)
            ID_IDLE: begin
                if (sel_found) begin
                    id_d       = sel_id;
                    id_state_d = ID_VALID;
                end
            end
            ID_VALID: begin
                if (irq_ack_i) begin
                    rr_d       = (id_q == IdW'(NumRcInt - 1)) ? '0 : id_q + 1'b1;
                    id_state_d = ID_IDLE;
                end
            end
            default: id_state_d = ID_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q    <= '0;
            ovf_q    <= '0;
            udf_q    <= '0;
            status_q <= '0;
            rise_q   <= '0;
            hyst_q   <= '{default: HYST_LOW};
            irq_q    <= 1'b0;
        end else begin
            lvl_q    <= lvl_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            status_q <= status_d;
            rise_q   <= rise_d;
            hyst_q   <= hyst_d;
            irq_q    <= irq_d;
        end
    end

    // ID port state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_state_q <= ID_IDLE;
            id_q       <= '0;
            rr_q       <= '0;
        end else begin
            id_state_q <= id_state_d;
            id_q       <= id_d;
            rr_q       <= rr_d;
        end
    end

    assign amf_rc_int_fifo_level = lvl_q;
    assign int_status_o          = status_q;
    assign ovf_o                 = ovf_q;
    assign udf_o                 = udf_q;
    assign irq_o                 = irq_q;
    assign irq_valid_o           = (id_state_q == ID_VALID);
    assign irq_id_o              = id_q;

    a_wm_order: assert property (@(posedge clk) disable iff (!rst_n)
        (hi_wm_i != '0) |-> (lo_wm_i < hi_wm_i));

endmodule

// File: doc/amf_rc_int_fifo_level_mon.md
Name: amf_rc_int_fifo_level_mon

Overview:
Parameterised per-channel FIFO occupancy tracker with watermark interrupts for the RC interrupt FIFOs. It is the successor to the fixed 8×3-bit level bus, generalised in channel count and depth. It counts push/pop strobes to produce the packed fifo level array and flags over/underflow. It also raises hysteretic high-watermark interrupts and serialises pending channels to a single valid/ack interrupt-ID port using round-robin order.

Parameters:
NumRcInt, 8, number of channels (1..32)
Depth, 7, maximum entries per channel FIFO (>=1)
LvlW, $clog2(Depth+1), width of each level field (derived; do not override)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
push_i  input  NumRcInt  per-channel push strobe
pop_i  input  NumRcInt  per-channel pop strobe
hi_wm_i  input  LvlW  high watermark, shared; 0 disables detection
lo_wm_i  input  LvlW  low watermark, shared; must be < hi_wm_i
int_mask_i  input  NumRcInt  1 = channel interrupt masked
int_clr_i  input  NumRcInt  write-1-to-clear of int_status_o
err_clr_i  input  NumRcInt  write-1-to-clear of ovf_o/udf_o
amf_rc_int_fifo_level  output  [NumRcInt-1:0][LvlW-1:0]  registered occupancy per channel
int_status_o  output  NumRcInt  sticky watermark-crossing status
ovf_o  output  NumRcInt  sticky overflow
udf_o  output  NumRcInt  sticky underflow
irq_o  output  1  OR of (int_status_o & ~int_mask_i), registered
irq_valid_o  output  1  interrupt-ID valid
irq_id_o  output  $clog2(NumRcInt) (min 1)  reported channel
irq_ack_i  input  1  consumer acknowledges irq_id_o

Behaviour:
- Reset (rst_n low, async): all outputs are 0. All channel levels are 0. Hysteresis states are LOW. The round-robin pointer is 0, so channel 0 has highest priority.
- Level per channel, updated at each clk edge:
  - push only, level<Depth: +1.
  - push only, level==Depth: push dropped, level held, ovf set.
  - pop only, level>0: -1.
  - pop only, level==0: ignored, udf set.
  - push and pop together: level unchanged, with no ovf/udf even at 0 or Depth.
- Latency: a strobe at edge N is visible on amf_rc_int_fifo_level after edge N.
- Hysteresis FSM per channel (evaluated on registered level):
  - LOW→HIGH when hi_wm_i!=0 and level>=hi_wm_i. On this transition, int_status set at the next edge (2 cycles after the causing push).
  - HIGH→LOW when level<=lo_wm_i.
  - Remaining in HIGH never re-sets status; only a new LOW→HIGH transition does.
  - hi_wm_i==0 forces LOW.
- Sticky bits: a set in the same cycle as int_clr_i/err_clr_i/ack-clear wins (set priority). Masking does not affect int_status_o.
- irq_o is registered, one cycle after pending (status & ~mask) changes.
- ID port FSM:
  - IDLE: if pending!=0, select the first pending channel at or after rr_ptr (wrapping modulo NumRcInt). Load irq_id_o, go to VALID (irq_valid_o=1 from the next cycle).
  - VALID: irq_id_o and irq_valid_o are held stable until irq_ack_i, even if that channel is masked or cleared meanwhile.
  - On ack: clear int_status[irq_id_o] (unless re-set that cycle), set rr_ptr=irq_id_o+1 (wrap), go to IDLE. irq_valid_o is low for at least one cycle between IDs.
  - irq_ack_i while in IDLE is ignored.
- Reset mid-operation: all state and FSMs return to reset values immediately. Dropped strobes are not replayed.
- lo_wm_i>=hi_wm_i (when hi_wm_i!=0) is an illegal configuration. An SVA assertion flags it; the behaviour is undefined.

Test Plan:
- Default params; push ch3 for 7 cycles, then 1 extra push → level[3] 1..7, 8th push dropped, level 7, ovf_o[3]=1; err_clr_i[3]=1 → ovf_o[3]=0.
- Pop ch0 at level 0 → udf_o[0]=1, level 0; push+pop same cycle at level 0 and at 7 → level unchanged, no ovf/udf.
- hi_wm=6, lo_wm=2; fill ch5 to 6 → int_status_o[5]=1 two cycles after the 6th push, irq_o=1 next cycle.
  - Clear it, pop to 4, push to 6 → no re-set.
  - Pop to 2, push to 6 → status set again.
- Status pending on ch1, ch4, ch6, none masked → IDs reported in order 1, 4, 6, each held until ack with a valid gap between IDs; all status cleared after 3 acks. A new ch1 event after ch6 ack → next ID 1 (wrap).
- ch2 pending with int_mask_i[2]=1 → irq_o=0, no ID; unmask → irq_o=1, irq_id_o=2.
- Assert rst_n low while irq_valid_o=1 and levels nonzero → all outputs 0 asynchronously; after release, pushes count from 0.
